// File: rtl/keypad_pkg.sv
// Shared types and constants for the checkout keypad front end:
// key-bit layout, entry phases and the one-hot digit decoder.
package keypad_pkg;

  localparam int KEY_W    = 14;
  localparam int DIGIT_W  = 10;
  localparam int K_ENTER  = 10;
  localparam int K_NUMBER = 11;
  localparam int K_TOTAL  = 12;
  localparam int K_CLR    = 13;

  typedef enum logic [1:0] {
    S_COST = 2'd0,
    S_QTY  = 2'd1,
    S_ERR  = 2'd2
  } phase_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] digit;
  } bcd_t;

  // valid only when exactly one key bit is set
  function automatic bcd_t onehot_to_bcd(input logic [DIGIT_W-1:0] oh);
    bcd_t r;
    r.valid = (oh != '0) && ((oh & (oh - 10'd1)) == '0);
    r.digit = 4'd0;
    for (int i = 0; i < DIGIT_W; i++) begin
      if (oh[i]) r.digit = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Key inputs and accumulator-facing outputs of the keypad entry block.
interface keypad_entry_if #(parameter int VAL_W = 11) ();

  logic [9:0]       key_digit;
  logic             key_enter;
  logic             key_number;
  logic             key_total;
  logic             key_clr;
  logic [VAL_W-1:0] cost_o;
  logic [VAL_W-1:0] qty_o;
  logic             enter_o;
  logic             number_o;
  logic             total_o;
  logic             clear_o;
  logic [VAL_W-1:0] entry_o;
  logic [2:0]       digits_o;
  logic             err_o;
  logic [1:0]       phase_o;

  modport master (
    output key_digit, key_enter, key_number, key_total, key_clr,
    input  cost_o, qty_o, enter_o, number_o, total_o, clear_o,
    input  entry_o, digits_o, err_o, phase_o
  );

  modport slave (
    input  key_digit, key_enter, key_number, key_total, key_clr,
    output cost_o, qty_o, enter_o, number_o, total_o, clear_o,
    output entry_o, digits_o, err_o, phase_o
  );

endinterface

// File: rtl/keypad_sync_edge.sv
// Two-flop synchronizer and rising-edge detector for raw push buttons;
// also exports the synchronized level of one selected bit.
module keypad_sync_edge #(
  parameter int W        = 14,
  parameter int HOLD_BIT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise_o,
  output logic         hold_o
);

  logic [W-1:0] s1_d, s1_q;
  logic [W-1:0] s2_d, s2_q;
  logic [W-1:0] prev_d, prev_q;

  always_comb begin
    s1_d   = din;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign rise_o = s2_q & ~prev_q;
  assign hold_o = s2_q[HOLD_BIT];

endmodule

// File: rtl/keypad_entry.sv
// Keypad front end: turns debounced key edges into multi-digit cost and
// quantity values with commit strobes for the checkout accumulator.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int VAL_W      = 11,
  parameter int MAX_VAL    = 2047,
  parameter int MAX_DIGITS = 4
) (
  input  logic           clk,
  input  logic           clear_n,
  keypad_entry_if.slave  bus
);

  localparam int NXT_W = VAL_W + 4;
  localparam logic [NXT_W-1:0] MAX_NXT = NXT_W'(MAX_VAL);

  logic [KEY_W-1:0] raw_keys, edg;
  logic             total_lvl;
  logic [K_CLR-1:0] cmd_edg;
  logic             multi;
  bcd_t             bcd;
  logic [NXT_W-1:0] nxt;

  phase_e           state_d, state_q;
  logic [VAL_W-1:0] entry_d, entry_q, cost_d, cost_q, qty_d, qty_q;
  logic [2:0]       digits_d, digits_q;
  logic             err_d, err_q, enter_d, enter_q, number_d, number_q;
  logic             total_d, total_q, clear_d, clear_q;

  assign raw_keys = {bus.key_clr, bus.key_total, bus.key_number, bus.key_enter, bus.key_digit};

  keypad_sync_edge #(.W(KEY_W), .HOLD_BIT(K_TOTAL)) u_sync (
    .clk    (clk),
    .rst_n  (clear_n),
    .din    (raw_keys),
    .rise_o (edg),
    .hold_o (total_lvl)
  );

  // more than one non-CLR edge in a cycle is a keying error
  assign cmd_edg = edg[K_CLR-1:0];
  assign multi   = |(cmd_edg & (cmd_edg - K_CLR'(1)));
  assign bcd     = onehot_to_bcd(edg[DIGIT_W-1:0]);
  assign nxt     = NXT_W'(entry_q) * NXT_W'(10) + NXT_W'(bcd.digit);

  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    digits_d = digits_q;
    err_d    = err_q;
    cost_d   = cost_q;
    qty_d    = qty_q;
    enter_d  = 1'b0;
    number_d = 1'b0;
    clear_d  = 1'b0;
    total_d  = total_q & total_lvl;

    if (edg[K_CLR]) begin
      state_d  = S_COST;
      entry_d  = '0;
      digits_d = '0;
      err_d    = 1'b0;
      clear_d  = 1'b1;
      total_d  = 1'b0;
    end else if (multi) begin
      state_d = S_ERR;
      err_d   = 1'b1;
      total_d = 1'b0;
    end else begin
      case (state_q)
        S_COST, S_QTY: begin
          if (bcd.valid) begin
            if (nxt > MAX_NXT || digits_q == 3'(MAX_DIGITS)) begin
              state_d = S_ERR;
              err_d   = 1'b1;
              total_d = 1'b0;
            end else begin
              entry_d  = nxt[VAL_W-1:0];
              digits_d = digits_q + 3'd1;
            end
          end else if (state_q == S_COST) begin
            if (edg[K_ENTER] && digits_q != '0) begin
              cost_d   = entry_q;
              enter_d  = 1'b1;
              entry_d  = '0;
              digits_d = '0;
              state_d  = S_QTY;
            end else if (edg[K_TOTAL] && digits_q == '0) begin
              total_d = 1'b1;
            end
          end else if (edg[K_NUMBER] && digits_q != '0) begin
            qty_d    = entry_q;
            number_d = 1'b1;
            entry_d  = '0;
            digits_d = '0;
            state_d  = S_COST;
          end
        end
        S_ERR: total_d = 1'b0;
        default: begin
          state_d = S_ERR;
          err_d   = 1'b1;
          total_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= S_COST;
      entry_q  <= '0;
      digits_q <= '0;
      err_q    <= 1'b0;
      cost_q   <= '0;
      qty_q    <= '0;
      enter_q  <= 1'b0;
      number_q <= 1'b0;
      clear_q  <= 1'b0;
      total_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      digits_q <= digits_d;
      err_q    <= err_d;
      cost_q   <= cost_d;
      qty_q    <= qty_d;
      enter_q  <= enter_d;
      number_q <= number_d;
      clear_q  <= clear_d;
      total_q  <= total_d;
    end
  end

  assign bus.cost_o   = cost_q;
  assign bus.qty_o    = qty_q;
  assign bus.enter_o  = enter_q;
  assign bus.number_o = number_q;
  assign bus.total_o  = total_q;
  assign bus.clear_o  = clear_q;
  assign bus.entry_o  = entry_q;
  assign bus.digits_o = digits_q;
  assign bus.err_o    = err_q;
  assign bus.phase_o  = state_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: key presses with hand-computed results.
module tb_keypad_entry;

  localparam logic [13:0] ENT = 14'h0400;
  localparam logic [13:0] NUM = 14'h0800;
  localparam logic [13:0] TOT = 14'h1000;
  localparam logic [13:0] CLR = 14'h2000;

  logic        clk = 1'b0;
  logic        clear_n = 1'b0;
  logic [13:0] keys = '0;
  int          npass = 0;
  int          ntotal = 0;
  int          enter_cnt, number_cnt, clear_cnt, total_cnt, total_first;

  always #5 clk = ~clk;

  keypad_entry_if bus ();

  assign bus.key_digit  = keys[9:0];
  assign bus.key_enter  = keys[10];
  assign bus.key_number = keys[11];
  assign bus.key_total  = keys[12];
  assign bus.key_clr    = keys[13];

  keypad_entry dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // press a key pattern for `hold` cycles, release for 3, counting strobes
  task automatic press(input logic [13:0] k, input int hold);
    enter_cnt = 0; number_cnt = 0; clear_cnt = 0; total_cnt = 0; total_first = 0;
    keys = k;
    for (int i = 1; i <= hold + 3; i++) begin
      @(posedge clk); #1;
      if (i == hold) keys = '0;
      if (bus.enter_o)  enter_cnt++;
      if (bus.number_o) number_cnt++;
      if (bus.clear_o)  clear_cnt++;
      if (bus.total_o) begin
        if (total_cnt == 0) total_first = i;
        total_cnt++;
      end
    end
  endtask

  function automatic logic [13:0] dig(input int d);
    logic [13:0] one;
    one = 14'd1;
    return one << d;
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_phase", 32'(bus.phase_o), 0);
    check("rst_err", 32'(bus.err_o), 0);
    check("rst_entry", 32'(bus.entry_o), 0);
    check("rst_cost", 32'(bus.cost_o), 0);
    clear_n = 1'b1;
    @(posedge clk); #1;

    // cost entry 125
    press(dig(1), 3); check("t1_entry1", 32'(bus.entry_o), 1);
    press(dig(2), 3); check("t1_entry12", 32'(bus.entry_o), 12);
    press(dig(5), 3); check("t1_entry125", 32'(bus.entry_o), 125);
    check("t1_digits", 32'(bus.digits_o), 3);
    press(ENT, 3);
    check("t1_enter_pulse", enter_cnt, 1);
    check("t1_cost", 32'(bus.cost_o), 125);
    check("t1_phase", 32'(bus.phase_o), 1);
    check("t1_entry_clr", 32'(bus.entry_o), 0);

    // quantity 3
    press(dig(3), 3); check("t2_entry", 32'(bus.entry_o), 3);
    press(NUM, 3);
    check("t2_number_pulse", number_cnt, 1);
    check("t2_enter_none", enter_cnt, 0);
    check("t2_qty", 32'(bus.qty_o), 3);
    check("t2_phase", 32'(bus.phase_o), 0);
    check("t2_cost_kept", 32'(bus.cost_o), 125);

    // overflow past 2047
    press(dig(2), 3); press(dig(0), 3); press(dig(4), 3);
    check("t3_entry204", 32'(bus.entry_o), 204);
    press(dig(8), 3);
    check("t3_err", 32'(bus.err_o), 1);
    check("t3_phase_err", 32'(bus.phase_o), 2);
    check("t3_entry_kept", 32'(bus.entry_o), 204);
    press(dig(7), 3);
    check("t3_err_ignore", 32'(bus.entry_o), 204);
    press(ENT, 3);
    check("t3_err_noenter", enter_cnt, 0);
    press(CLR, 3);
    check("t3_clear_pulse", clear_cnt, 1);
    check("t3_err_clr", 32'(bus.err_o), 0);
    check("t3_phase_clr", 32'(bus.phase_o), 0);
    check("t3_entry_clr", 32'(bus.entry_o), 0);
    check("t3_cost_kept", 32'(bus.cost_o), 125);

    // simultaneous edges
    press(14'b00000000000101, 3);
    check("t4_multi_err", 32'(bus.err_o), 1);
    check("t4_multi_entry", 32'(bus.entry_o), 0);
    press(CLR, 3);
    press(dig(9), 3);
    press(ENT | dig(4), 3);
    check("t4_cmd_err", 32'(bus.err_o), 1);
    check("t4_cmd_entry", 32'(bus.entry_o), 9);
    check("t4_cmd_noenter", enter_cnt, 0);
    press(CLR, 3);

    // digit-count limit and exact maximum
    press(dig(0), 3); press(dig(0), 3); press(dig(1), 3); press(dig(2), 3);
    check("t4_lead_zero", 32'(bus.digits_o), 4);
    press(dig(3), 3);
    check("t4_fifth_err", 32'(bus.err_o), 1);
    check("t4_fifth_entry", 32'(bus.entry_o), 12);
    press(CLR, 3);
    press(dig(2), 3); press(dig(0), 3); press(dig(4), 3); press(dig(7), 3);
    check("t4_max_ok", 32'(bus.err_o), 0);
    check("t4_max_entry", 32'(bus.entry_o), 2047);
    press(ENT, 3);
    check("t4_max_cost", 32'(bus.cost_o), 2047);

    // TOTAL gating
    press(TOT, 6);
    check("t5_total_qty", total_cnt, 0);
    press(dig(1), 3); press(NUM, 3);
    check("t5_qty1", 32'(bus.qty_o), 1);
    press(TOT, 6);
    check("t5_total_len", total_cnt, 6);
    check("t5_total_delay", total_first, 3);
    press(dig(5), 3);
    press(TOT, 6);
    check("t5_total_digits", total_cnt, 0);
    press(CLR, 3);

    // long hold acts once
    press(dig(3), 8);
    check("hold_once_entry", 32'(bus.entry_o), 3);
    check("hold_once_digits", 32'(bus.digits_o), 1);
    press(CLR, 3);

    // asynchronous reset mid-cycle
    press(dig(1), 3); press(dig(2), 3);
    check("t6_entry12", 32'(bus.entry_o), 12);
    @(posedge clk); #3;
    clear_n = 1'b0;
    #1;
    check("t6_async_entry", 32'(bus.entry_o), 0);
    check("t6_async_digits", 32'(bus.digits_o), 0);
    check("t6_async_cost", 32'(bus.cost_o), 0);
    check("t6_async_qty", 32'(bus.qty_o), 0);
    repeat (2) @(posedge clk);
    #1;
    clear_n = 1'b1;
    @(posedge clk); #1;
    press(dig(7), 3); press(ENT, 3);
    check("t6_cost7", 32'(bus.cost_o), 7);
    check("t6_phase", 32'(bus.phase_o), 1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
